// File: rtl/wb_load_rf.sv
// Write-back stage for the three-stage RISC-V core: owns the architectural
// register file, commits ALU results and (sign/zero-extended) load data,
// stalls while a load response is outstanding with a timeout fault, and
// offers two bypassed combinational read ports to decode.
module wb_load_rf #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_alu_to_reg,
  input  logic            wb_mem_to_reg,
  input  logic [4:0]      wb_dest_reg_sel,
  input  logic [XLEN-1:0] wb_result,
  input  logic [2:0]      wb_alu_operation,
  input  logic [1:0]      wb_read_address,
  input  logic [XLEN-1:0] dmem_read_data,
  input  logic            dmem_read_valid,
  output logic            dmem_read_ready,
  input  logic [4:0]      src1_select,
  input  logic [4:0]      src2_select,
  output logic [XLEN-1:0] reg_rdata1,
  output logic [XLEN-1:0] reg_rdata2,
  output logic            wb_stall,
  output logic            load_fault
);

  localparam int AW = $clog2(NUM_REGS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [7:0] TIMEOUT_C  = 8'(LOAD_TIMEOUT);
  localparam logic [5:0] NUM_REGS_C = 6'(NUM_REGS);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Pick the addressed byte/half of the aligned word and extend it to XLEN.
  // Unknown load encodings commit zero rather than garbage.
  function automatic logic [XLEN-1:0] extract_load(
    input logic [2:0]      f3,
    input logic [1:0]      a,
    input logic [XLEN-1:0] w
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   r = {{(XLEN-8){b[7]}}, b};
      F3_LBU:  r = {{(XLEN-8){1'b0}}, b};
      F3_LH:   r = {{(XLEN-16){h[15]}}, h};
      F3_LHU:  r = {{(XLEN-16){1'b0}}, h};
      F3_LW:   r = w;
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [0:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            fault_q, fault_d;

  logic            load_req_s;
  logic            alu_wr_s;
  logic            load_done_s;
  logic            timeout_hit_s;
  logic            dest_ok_s;
  logic            wr_en_s;
  logic [XLEN-1:0] wr_data_s;

  assign load_req_s    = wb_valid & wb_alu_to_reg & wb_mem_to_reg;
  assign alu_wr_s      = wb_valid & wb_alu_to_reg & ~wb_mem_to_reg;
  assign load_done_s   = load_req_s & dmem_read_valid;
  assign timeout_hit_s = (state_q == ST_WAIT) & (cnt_q == TIMEOUT_C) & ~dmem_read_valid;
  assign dest_ok_s     = (wb_dest_reg_sel != 5'd0) & ({1'b0, wb_dest_reg_sel} < NUM_REGS_C);
  // Reset blocks any commit, so a load aborted by reset never lands.
  assign wr_en_s       = ~reset & (alu_wr_s | load_done_s) & dest_ok_s;
  assign wr_data_s     = alu_wr_s ? wb_result
                                  : extract_load(wb_alu_operation, wb_read_address, dmem_read_data);

  // Handshake outputs are combinational; reset forces them idle.
  assign dmem_read_ready = ~reset & load_req_s;
  assign wb_stall        = ~reset & load_req_s & ~dmem_read_valid & ~timeout_hit_s;
  assign load_fault      = fault_q;

  // Next-state logic for the load wait FSM, its stall counter and fault pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_req_s && !dmem_read_valid) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      end
      ST_WAIT: begin
        if (!load_req_s) begin
          // Flush: the load left the stage, abandon it quietly.
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (dmem_read_valid) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (timeout_hit_s) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          fault_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // FSM, counter and fault pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Register file storage: clear on reset, otherwise commit one write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_q[wb_dest_reg_sel[AW-1:0]] <= wr_data_s;
    end else begin
      regs_q <= regs_q;
    end
  end

  // Read port 1: x0 and out-of-range read zero, same-cycle writes bypass.
  always_comb begin
    reg_rdata1 = {XLEN{1'b0}};
    if ((src1_select == 5'd0) || ({1'b0, src1_select} >= NUM_REGS_C)) begin
      reg_rdata1 = {XLEN{1'b0}};
    end else if (wr_en_s && (src1_select == wb_dest_reg_sel)) begin
      reg_rdata1 = wr_data_s;
    end else begin
      reg_rdata1 = regs_q[src1_select[AW-1:0]];
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    reg_rdata2 = {XLEN{1'b0}};
    if ((src2_select == 5'd0) || ({1'b0, src2_select} >= NUM_REGS_C)) begin
      reg_rdata2 = {XLEN{1'b0}};
    end else if (wr_en_s && (src2_select == wb_dest_reg_sel)) begin
      reg_rdata2 = wr_data_s;
    end else begin
      reg_rdata2 = regs_q[src2_select[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_wb_load_rf.sv
// Directed bench for wb_load_rf. Two instances share every input: "a" uses
// the default RV32I build (32 regs, timeout 15), "b" is an RV32E build with a
// short timeout (16 regs, timeout 4), so boundary behaviour differs per copy.
module tb_wb_load_rf;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_alu_to_reg, wb_mem_to_reg;
  logic [4:0]  wb_dest_reg_sel;
  logic [31:0] wb_result;
  logic [2:0]  wb_alu_operation;
  logic [1:0]  wb_read_address;
  logic [31:0] dmem_read_data;
  logic        dmem_read_valid;
  logic [4:0]  src1_select, src2_select;

  logic        ready_a, stall_a, fault_a;
  logic [31:0] rd1_a, rd2_a;
  logic        ready_b, stall_b, fault_b;
  logic [31:0] rd1_b, rd2_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_load_rf #(.XLEN(32), .NUM_REGS(32), .LOAD_TIMEOUT(15)) dut_a (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_alu_to_reg(wb_alu_to_reg),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_dest_reg_sel(wb_dest_reg_sel), .wb_result(wb_result),
    .wb_alu_operation(wb_alu_operation), .wb_read_address(wb_read_address),
    .dmem_read_data(dmem_read_data), .dmem_read_valid(dmem_read_valid),
    .dmem_read_ready(ready_a), .src1_select(src1_select), .src2_select(src2_select),
    .reg_rdata1(rd1_a), .reg_rdata2(rd2_a), .wb_stall(stall_a), .load_fault(fault_a)
  );

  wb_load_rf #(.XLEN(32), .NUM_REGS(16), .LOAD_TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_alu_to_reg(wb_alu_to_reg),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_dest_reg_sel(wb_dest_reg_sel), .wb_result(wb_result),
    .wb_alu_operation(wb_alu_operation), .wb_read_address(wb_read_address),
    .dmem_read_data(dmem_read_data), .dmem_read_valid(dmem_read_valid),
    .dmem_read_ready(ready_b), .src1_select(src1_select), .src2_select(src2_select),
    .reg_rdata1(rd1_b), .reg_rdata2(rd2_b), .wb_stall(stall_b), .load_fault(fault_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to mid-cycle (falling edge) where outputs are sampled.
  task automatic mid();
    #4;
  endtask

  task automatic drive(input logic v, input logic alu, input logic mem, input logic [4:0] dest,
                       input logic [31:0] res, input logic [2:0] op, input logic [1:0] addr,
                       input logic [31:0] data, input logic rv);
    wb_valid = v; wb_alu_to_reg = alu; wb_mem_to_reg = mem; wb_dest_reg_sel = dest;
    wb_result = res; wb_alu_operation = op; wb_read_address = addr;
    dmem_read_data = data; dmem_read_valid = rv;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 32'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    src1_select = 5'd5;
    src2_select = 5'd7;
    tick();
    tick();

    // Reset state
    reset = 1'b0;
    mid();
    chk("rst_rd1_a", rd1_a, 32'h0);
    chk("rst_stall_a", {31'b0, stall_a}, 32'd0);
    chk("rst_ready_a", {31'b0, ready_a}, 32'd0);
    chk("rst_fault_a", {31'b0, fault_a}, 32'd0);
    chk("rst_fault_b", {31'b0, fault_b}, 32'd0);
    tick();

    // 1: ALU write to x5 with same-cycle bypass, then stored value
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234_5678, 3'b000, 2'd0, 32'h0, 1'b0);
    mid();
    chk("alu_byp_a", rd1_a, 32'h1234_5678);
    chk("alu_byp_b", rd1_b, 32'h1234_5678);
    chk("alu_stall", {31'b0, stall_a}, 32'd0);
    chk("alu_ready", {31'b0, ready_a}, 32'd0);
    tick();
    idle();
    mid();
    chk("alu_store_a", rd1_a, 32'h1234_5678);
    chk("alu_store_b", rd1_b, 32'h1234_5678);
    tick();

    // 2: same-cycle loads into x7 (port 2 observes bypass)
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 3'b000, 2'd3, 32'h80FF_0000, 1'b1);
    mid();
    chk("lb_byp", rd2_a, 32'hFFFF_FF80);
    chk("lb_stall", {31'b0, stall_a}, 32'd0);
    chk("lb_ready", {31'b0, ready_a}, 32'd1);
    tick();
    idle();
    mid();
    chk("lb_store_a", rd2_a, 32'hFFFF_FF80);
    chk("lb_store_b", rd2_b, 32'hFFFF_FF80);
    tick();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 3'b100, 2'd3, 32'h80FF_0000, 1'b1);
    mid();
    chk("lbu_byp", rd2_a, 32'h0000_0080);
    tick();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 3'b101, 2'd2, 32'h80FF_0000, 1'b1);
    mid();
    chk("lhu_byp", rd2_a, 32'h0000_80FF);
    tick();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 3'b001, 2'd3, 32'h80FF_0000, 1'b1);
    mid();
    chk("lh_a3_byp", rd2_b, 32'hFFFF_80FF);
    tick();
    idle();
    mid();
    chk("lh_store", rd2_a, 32'hFFFF_80FF);
    tick();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 3'b001, 2'd0, 32'h1234_8765, 1'b1);
    mid();
    chk("lh_lo_byp", rd2_a, 32'hFFFF_8765);
    tick();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 3'b011, 2'd0, 32'hDEAD_BEEF, 1'b1);
    mid();
    chk("bad_f3_byp", rd2_a, 32'h0);
    tick();
    idle();
    mid();
    chk("bad_f3_store", rd2_b, 32'h0);
    tick();

    // 3: delayed load into x9, valid arrives after 3 stall cycles
    src1_select = 5'd9;
    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h0, 3'b010, 2'd0, 32'hCAFE_F00D, 1'b0);
    mid();
    chk("dly_c0_stall", {31'b0, stall_a}, 32'd1);
    chk("dly_c0_ready", {31'b0, ready_a}, 32'd1);
    tick();
    mid();
    chk("dly_c1_stall", {31'b0, stall_a}, 32'd1);
    chk("dly_c1_ready", {31'b0, ready_b}, 32'd1);
    tick();
    mid();
    chk("dly_c2_stall_b", {31'b0, stall_b}, 32'd1);
    chk("dly_c2_nowr", rd1_a, 32'h0);
    tick();
    dmem_read_valid = 1'b1;
    mid();
    chk("dly_c3_stall", {31'b0, stall_a}, 32'd0);
    chk("dly_c3_ready", {31'b0, ready_a}, 32'd1);
    chk("dly_c3_byp", rd1_a, 32'hCAFE_F00D);
    tick();
    idle();
    mid();
    chk("dly_store_a", rd1_a, 32'hCAFE_F00D);
    chk("dly_store_b", rd1_b, 32'hCAFE_F00D);
    chk("dly_ready_off", {31'b0, ready_a}, 32'd0);
    chk("dly_fault", {31'b0, fault_a}, 32'd0);
    tick();
    // back in IDLE: an immediate load completes with no stall
    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h0, 3'b010, 2'd0, 32'h0BAD_CAFE, 1'b1);
    mid();
    chk("dly_idle_stall_b", {31'b0, stall_b}, 32'd0);
    chk("dly_idle_byp", rd1_b, 32'h0BAD_CAFE);
    tick();

    // 4: timeout on x10 (b times out after 4 stall cycles, a is flushed)
    src1_select = 5'd10;
    drive(1'b1, 1'b1, 1'b1, 5'd10, 32'h0, 3'b010, 2'd0, 32'h5555_AAAA, 1'b0);
    for (int c = 0; c < 4; c++) begin
      mid();
      chk($sformatf("to_c%0d_stall_b", c), {31'b0, stall_b}, 32'd1);
      chk($sformatf("to_c%0d_fault_b", c), {31'b0, fault_b}, 32'd0);
      tick();
    end
    mid();
    chk("to_hit_stall_b", {31'b0, stall_b}, 32'd0);
    chk("to_hit_stall_a", {31'b0, stall_a}, 32'd1);
    chk("to_hit_nowr_b", rd1_b, 32'h0);
    chk("to_hit_fault_b", {31'b0, fault_b}, 32'd0);
    tick();
    idle();
    mid();
    chk("to_pulse_b", {31'b0, fault_b}, 32'd1);
    chk("to_nofault_a", {31'b0, fault_a}, 32'd0);
    tick();
    mid();
    chk("to_pulse_end_b", {31'b0, fault_b}, 32'd0);
    chk("flush_nofault_a", {31'b0, fault_a}, 32'd0);
    chk("to_nowr_a", rd1_a, 32'h0);
    chk("to_nowr_b", rd1_b, 32'h0);
    chk("to_stall_a", {31'b0, stall_a}, 32'd0);
    tick();

    // 5: x0 and RV32E range limits
    src1_select = 5'd0;
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 3'b000, 2'd0, 32'h0, 1'b0);
    mid();
    chk("x0_byp", rd1_a, 32'h0);
    tick();
    idle();
    mid();
    chk("x0_store", rd1_a, 32'h0);
    tick();
    src1_select = 5'd20;
    src2_select = 5'd4;
    drive(1'b1, 1'b1, 1'b0, 5'd20, 32'hA5A5_A5A5, 3'b000, 2'd0, 32'h0, 1'b0);
    mid();
    chk("x20_byp_a", rd1_a, 32'hA5A5_A5A5);
    chk("x20_byp_b", rd1_b, 32'h0);
    tick();
    idle();
    mid();
    chk("x20_store_a", rd1_a, 32'hA5A5_A5A5);
    chk("x20_store_b", rd1_b, 32'h0);
    chk("x4_alias_b", rd2_b, 32'h0);
    tick();

    // 6: reset while waiting on a load into x11
    src1_select = 5'd5;
    src2_select = 5'd11;
    drive(1'b1, 1'b1, 1'b1, 5'd11, 32'h0, 3'b010, 2'd0, 32'h7777_7777, 1'b0);
    mid();
    chk("rl_stall", {31'b0, stall_a}, 32'd1);
    tick();
    reset = 1'b1;
    mid();
    chk("rl_rst_stall", {31'b0, stall_a}, 32'd0);
    chk("rl_rst_ready", {31'b0, ready_b}, 32'd0);
    tick();
    reset = 1'b0;
    idle();
    mid();
    chk("rl_x5_a", rd1_a, 32'h0);
    chk("rl_x5_b", rd1_b, 32'h0);
    chk("rl_x11", rd2_a, 32'h0);
    chk("rl_stall_after", {31'b0, stall_a}, 32'd0);
    chk("rl_ready_after", {31'b0, ready_a}, 32'd0);
    chk("rl_fault_a", {31'b0, fault_a}, 32'd0);
    tick();
    mid();
    chk("rl_fault_a2", {31'b0, fault_a}, 32'd0);
    chk("rl_fault_b2", {31'b0, fault_b}, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
